// File: rtl/cb_rc_seq.sv
// -----------------------------------------------------------------------------
// cb_rc_seq -- covariance-block row/column sequence generator.
//
// Accepts one access request, then issues the CB_row/CB_col pairs of the
// requested rectangle (row-major, one per unstalled cycle) to the CB address
// generator. A valid/last token pipeline, AGD_LAT deep, tracks the address
// generator latency so addr_valid qualifies CB_base_addr and seq_done marks
// the end of the sequence.
//
// Optional feature macro: CB_SEQ_SYMM_EN
//   defined   : elements with col > row consume an issue cycle but are issued
//               with rc_valid=0 (lower-triangle reads only). The last token is
//               still emitted on (r1,c1).
//   undefined : every element of the rectangle is issued.
//
// Ports:
//   clk, sys_rst            clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_mode                0 pose, 1 column strip, 2 landmark block, 3 row strip
//   req_lm_idx              landmark index k
//   total_rows              state dimension N, sampled at accept
//   stall                   holds issue while in ISSUE
//   CB_row / CB_col         registered indices to the address generator
//   rc_valid                CB_row/CB_col valid
//   addr_valid, addr_last   rc_valid / last token delayed AGD_LAT cycles
//   seq_done                sequence fully drained (same as addr_last)
//   req_err                 one-cycle pulse for a rejected request
// -----------------------------------------------------------------------------
module cb_rc_seq #(
    parameter int ROW_LEN      = 10,
    parameter int MAX_LANDMARK = 500,
    parameter int AGD_LAT      = 5
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_mode,
    input  logic [ROW_LEN-1:0] req_lm_idx,
    input  logic [ROW_LEN-1:0] total_rows,
    input  logic               stall,
    output logic [ROW_LEN-1:0] CB_row,
    output logic [ROW_LEN-1:0] CB_col,
    output logic               rc_valid,
    output logic               addr_valid,
    output logic               addr_last,
    output logic               seq_done,
    output logic               req_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ROW_LEN-1:0] r1_q, r1_d, c0_q, c0_d, c1_q, c1_d;
    logic [ROW_LEN-1:0] row_q, row_d, col_q, col_d;
    logic [ROW_LEN-1:0] cb_row_q, cb_row_d, cb_col_q, cb_col_d;
    logic               rc_valid_q, rc_valid_d;
    logic               last_q, last_d;
    logic               req_err_q, req_err_d;
    logic [AGD_LAT-1:0] vpipe_q, vpipe_d;
    logic [AGD_LAT-1:0] lpipe_q, lpipe_d;

    // Rectangle decode for the request currently on the input
    logic [ROW_LEN-1:0] lm_base;
    logic [ROW_LEN:0]   lm_end;
    logic [ROW_LEN-1:0] n_last;
    logic [ROW_LEN-1:0] rect_r0, rect_r1, rect_c0, rect_c1;
    logic               reject;
    logic               elem_en;
    logic               at_last;

    always_comb begin
        lm_base = ROW_LEN'(3) + (req_lm_idx << 1);
        // One extra bit so c+2 cannot wrap before the compare with N
        lm_end  = {1'b0, lm_base} + (ROW_LEN+1)'(2);
        n_last  = total_rows - ROW_LEN'(1);
        rect_r0 = lm_base;
        rect_r1 = lm_base + ROW_LEN'(1);
        rect_c0 = lm_base;
        rect_c1 = lm_base + ROW_LEN'(1);
        reject  = (req_lm_idx >= ROW_LEN'(MAX_LANDMARK)) ||
                  (lm_end > {1'b0, total_rows});
        case (req_mode)
            2'd0: begin
                rect_r0 = '0;
                rect_r1 = ROW_LEN'(2);
                rect_c0 = '0;
                rect_c1 = ROW_LEN'(2);
                reject  = (total_rows < ROW_LEN'(3));
            end
            2'd1: begin
                rect_r0 = '0;
                rect_r1 = n_last;
            end
            2'd3: begin
                rect_c0 = '0;
                rect_c1 = n_last;
            end
            default: ;
        endcase
    end

    // Suppress the upper triangle when symmetric reads are enabled
`ifdef CB_SEQ_SYMM_EN
    assign elem_en = (col_q <= row_q);
`else
    assign elem_en = 1'b1;
`endif

    assign at_last = (row_q == r1_q) && (col_q == c1_q);

    // Token pipelines: never stall, always shift
    generate
        for (genvar gi = 0; gi < AGD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign vpipe_d[gi] = rc_valid_q;
                assign lpipe_d[gi] = last_q;
            end else begin : g_tail
                assign vpipe_d[gi] = vpipe_q[gi-1];
                assign lpipe_d[gi] = lpipe_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        r1_d       = r1_q;
        c0_d       = c0_q;
        c1_d       = c1_q;
        row_d      = row_q;
        col_d      = col_q;
        cb_row_d   = cb_row_q;
        cb_col_d   = cb_col_q;
        rc_valid_d = 1'b0;
        last_d     = 1'b0;
        req_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        req_err_d = 1'b1;
                    end else begin
                        r1_d    = rect_r1;
                        c0_d    = rect_c0;
                        c1_d    = rect_c1;
                        row_d   = rect_r0;
                        col_d   = rect_c0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    rc_valid_d = elem_en;
                    if (elem_en) begin
                        cb_row_d = row_q;
                        cb_col_d = col_q;
                    end
                    if (at_last) begin
                        last_d  = 1'b1;
                        state_d = S_DRAIN;
                    end else if (col_q == c1_q) begin
                        col_d = c0_q;
                        row_d = row_q + ROW_LEN'(1);
                    end else begin
                        col_d = col_q + ROW_LEN'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the last token exits the pipeline
                if (lpipe_q[AGD_LAT-1]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            r1_q       <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cb_row_q   <= '0;
            cb_col_q   <= '0;
            rc_valid_q <= 1'b0;
            last_q     <= 1'b0;
            req_err_q  <= 1'b0;
            vpipe_q    <= '0;
            lpipe_q    <= '0;
        end else begin
            state_q    <= state_d;
            r1_q       <= r1_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cb_row_q   <= cb_row_d;
            cb_col_q   <= cb_col_d;
            rc_valid_q <= rc_valid_d;
            last_q     <= last_d;
            req_err_q  <= req_err_d;
            vpipe_q    <= vpipe_d;
            lpipe_q    <= lpipe_d;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0
    assign req_ready  = (state_q == S_IDLE) && !sys_rst;
    assign CB_row     = cb_row_q;
    assign CB_col     = cb_col_q;
    assign rc_valid   = rc_valid_q;
    assign addr_valid = vpipe_q[AGD_LAT-1];
    assign addr_last  = lpipe_q[AGD_LAT-1];
    assign seq_done   = lpipe_q[AGD_LAT-1];
    assign req_err    = req_err_q;

endmodule

// File: doc/cb_rc_seq.md
# cb_rc_seq

Row/column sequence generator for covariance-block (CB) accesses in the EKF-SLAM datapath. It accepts one access request and issues the `CB_row`/`CB_col` pairs for the request's rectangle, one pair per cycle in row-major order. These pairs feed the CB address generator directly. A valid/last token pipeline is matched to the address generator's fixed latency, so downstream logic knows exactly when `CB_base_addr` is valid and when the sequence is complete.

## Interface
- `ROW_LEN`, 10, width of row/col indices and `total_rows`.
- `MAX_LANDMARK`, 500, highest legal landmark count; `req_lm_idx` must be < this.
- `AGD_LAT`, 5, cycles from a registered `CB_row`/`CB_col` to the matching `CB_base_addr`.
- `clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_mode`  in  2  access pattern, see Operation.
- `req_lm_idx`  in  ROW_LEN  landmark index k.
- `total_rows`  in  ROW_LEN  current state dimension N (3+2·landmarks); sampled at accept.
- `stall`  in  1  hold issue (downstream back-pressure).
- `CB_row`  out  ROW_LEN  registered row index to address generator.
- `CB_col`  out  ROW_LEN  registered column index to address generator.
- `rc_valid`  out  1  `CB_row`/`CB_col` valid this cycle.
- `addr_valid`  out  1  `rc_valid` delayed AGD_LAT cycles (qualifies `CB_base_addr`).
- `addr_last`  out  1  last-token delayed AGD_LAT cycles.
- `seq_done`  out  1  one-cycle pulse, sequence fully drained (equals `addr_last`).
- `req_err`  out  1  one-cycle pulse, request rejected.

## Operation
- Landmark base: c = 3 + 2·k, computed at ROW_LEN bits.
- Rectangle (rows r0..r1, cols c0..c1) per `req_mode`:
  - 0 pose: rows 0..2, cols 0..2.
  - 1 column strip: rows 0..N-1, cols c..c+1.
  - 2 landmark block: rows c..c+1, cols c..c+1.
  - 3 row strip: rows c..c+1, cols 0..N-1.
- Reject check, applied in IDLE on accept:
  - Modes 1–3 are rejected if k ≥ MAX_LANDMARK or c+2 > N.
  - Mode 0 is rejected if N < 3.
  - On reject: `req_err` pulses the next cycle, nothing is issued, and the FSM stays in IDLE.
- FSM states: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: `req_ready`=1. The request is accepted on the edge where `req_valid`&`req_ready`=1. Accept latches r0, r1, c0, c1 and loads counters row=r0, col=c0.
- ISSUE, at each edge with `stall`=0:
  - `CB_row`/`CB_col` load (row,col); `rc_valid`<=1.
  - col increments; when col=c1 it wraps to c0 and row increments.
  - The element (r1,c1) sets the last token, and the FSM moves to DRAIN.
- ISSUE, at an edge with `stall`=1: counters hold, `rc_valid`<=0, no token is inserted.
- DRAIN: no issue. The FSM waits for the last token to exit the AGD_LAT-deep pipeline. `seq_done` and `addr_last` pulse in the same cycle, then the FSM goes to IDLE.
- `stall` is ignored outside ISSUE. The address pipeline itself never stalls; in-flight tokens always advance.
- `CB_row`/`CB_col` hold their last value while `rc_valid`=0.
- Reset values: all outputs 0; FSM in IDLE; token pipelines cleared.
- Reset mid-operation: `sys_rst` clears the sequence and the pipeline immediately. No `seq_done` is produced for the aborted request.

## Timing
- Accept at edge E0.
- First pair is registered at E1 (`rc_valid`=1 after E1), provided `stall`=0 at E1.
- `addr_valid` for that pair is high after E1+AGD_LAT.
- Issue rate: one element per unstalled cycle.
- An R×C rectangle with no stalls has its last pair at E(R·C). `seq_done` pulses after E(R·C)+AGD_LAT. `req_ready` rises one cycle later.
- `req_err` pulses in the cycle after the rejected accept edge.

## Configuration
- `CB_SEQ_SYMM_EN` defined: elements with col > row still consume an issue cycle and advance counters, but issue with `rc_valid`=0. This exploits covariance symmetry by reading only the lower triangle. The last token is still issued on (r1,c1), even if that element is suppressed.
- `CB_SEQ_SYMM_EN` undefined: every element of the rectangle is issued with `rc_valid`=1.

## Test plan
- Mode 0, N=7, no stall: 9 pairs (0,0),(0,1)…(2,2), starting after E1. `seq_done` pulses after E14. `req_ready` is back high after E15.
- Mode 1, k=0, N=7: 14 pairs, rows 0..6 × cols 3,4. `addr_valid` is high for 14 consecutive cycles, starting AGD_LAT cycles after the first `rc_valid`.
- Mode 2, k=1, N=9, with `stall` high for 3 cycles after the 2nd pair:
  - Pairs issued: (5,5),(5,6),(6,5),(6,6).
  - `rc_valid` shows a 3-cycle gap, also reflected in `addr_valid`.
  - `seq_done` is delayed by 3 cycles.
- Mode 1, k=2, N=7 (c+2=9>7): `req_err` pulses once; `rc_valid` stays 0; `req_ready` stays 1.
- With `CB_SEQ_SYMM_EN`, mode 3, k=0, N=5: `rc_valid` is asserted for cols 0..3 on row 3 and cols 0..4 on row 4 (9 valid of 10 issue cycles). `seq_done` still pulses.
- Assert `sys_rst` during ISSUE of mode 1:
  - All outputs go to 0 immediately.
  - No `addr_valid` or `seq_done` appears afterwards.
  - The next request runs from scratch correctly.
